// File: rtl/gametank_bus_ctrl_pkg.sv
// Shared types and default memory map for the GameTank bus controller.
package gametank_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } bus_state_t;

    localparam int WAIT_W = 4;

    // Default map: region 0 ROM ($8000-$FFFF), 1 RAM ($0000-$1FFF),
    // 2 VIA ($2800-$280F), 3 blitter/banked window ($4000-$7FFF).
    localparam logic [63:0] DEF_REGION_BASE = {16'h4000, 16'h2800, 16'h0000, 16'h8000};
    localparam logic [63:0] DEF_REGION_MASK = {16'hC000, 16'hFFF0, 16'hE000, 16'h8000};
    localparam logic [15:0] DEF_REGION_WAIT = {4'd2, 4'd1, 4'd0, 4'd1};

    // Width of a region index; never zero so single-region builds still have a bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gametank_bus_ctrl_decoder.sv
// Combinational priority address decoder: base/mask windows, lowest index wins.
module bus_region_decoder
    import gametank_bus_ctrl_pkg::*;
#(
    parameter int                            NUM_REGIONS = 4,
    parameter int                            ADDR_W      = 16,
    parameter int                            IDX_W       = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic                   hit,
    output logic [NUM_REGIONS-1:0] onehot,
    output logic [IDX_W-1:0]       idx
);

    // Scan from the highest index down so the lowest matching window is left in idx.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if ((addr & REGION_MASK[k*ADDR_W +: ADDR_W]) == REGION_BASE[k*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
        if (hit) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/gametank_bus_ctrl.sv
// Bus control unit between the 6502 core and the decoded memory/IO regions:
// address decode, per-region wait-state sequencing, CPU stall and read-data return.
module gametank_bus_ctrl
    import gametank_bus_ctrl_pkg::*;
#(
    parameter int                            NUM_REGIONS   = 4,
    parameter int                            ADDR_W        = 16,
    parameter int                            DATA_W        = 8,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE   = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK   = DEF_REGION_MASK,
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT   = DEF_REGION_WAIT,
    parameter bit                            OPEN_BUS_MODE = 1'b1,
    parameter logic [DATA_W-1:0]             DEFAULT_DATA  = 8'hFF
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic                          i_nrd,
    input  logic                          i_nwr,
    input  logic [DATA_W-1:0]             i_wdata,
    output logic [DATA_W-1:0]             o_rdata,
    output logic                          o_rdy,
    output logic [NUM_REGIONS-1:0]        o_ce,
    output logic                          o_rnw,
    output logic [ADDR_W-1:0]             o_addr,
    output logic [DATA_W-1:0]             o_wdata,
    output logic                          o_we,
    input  logic [NUM_REGIONS*DATA_W-1:0] i_rdata,
    output logic                          o_unmapped,
    output logic                          o_bus_err
);

    localparam int IDX_W = idx_width(NUM_REGIONS);

    bus_state_t               state;
    logic [WAIT_W-1:0]        cnt;
    logic [IDX_W-1:0]         region_l;
    logic                     hit_l;
    logic                     strobe_d;
    logic                     last_valid;
    logic [ADDR_W-1:0]        last_addr;
    logic                     last_rnw;

    logic                     dec_hit;
    logic [NUM_REGIONS-1:0]   dec_onehot;
    logic [IDX_W-1:0]         dec_idx;
    logic [WAIT_W-1:0]        dec_wait;
    logic                     strobe;
    logic                     req_rnw;
    logic                     request;
    logic [DATA_W-1:0]        rd_sel;

    bus_region_decoder #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .IDX_W       (IDX_W),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decoder (
        .addr   (i_addr),
        .hit    (dec_hit),
        .onehot (dec_onehot),
        .idx    (dec_idx)
    );

    // Request qualification: a fresh strobe, or a held strobe moved to a new address/direction.
    // A write strobe dominates, so nRD+nWR together is handled as a write.
    always_comb begin
        strobe   = !i_nrd || !i_nwr;
        req_rnw  = i_nwr;
        dec_wait = dec_hit ? REGION_WAIT[dec_idx*WAIT_W +: WAIT_W] : '0;
        rd_sel   = i_rdata[region_l*DATA_W +: DATA_W];
        request  = strobe && (!strobe_d || !last_valid ||
                              (i_addr != last_addr) || (req_rnw != last_rnw));
    end

    // Access sequencer with registered CPU/region-side outputs.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            region_l   <= '0;
            hit_l      <= 1'b0;
            strobe_d   <= 1'b0;
            last_valid <= 1'b0;
            last_addr  <= '0;
            last_rnw   <= 1'b1;
            o_rdy      <= 1'b1;
            o_ce       <= '0;
            o_we       <= 1'b0;
            o_rnw      <= 1'b1;
            o_addr     <= '0;
            o_wdata    <= '0;
            o_rdata    <= DEFAULT_DATA;
            o_unmapped <= 1'b0;
            o_bus_err  <= 1'b0;
        end else begin
            strobe_d <= strobe;
            if (!i_nrd && !i_nwr) begin
                o_bus_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (request) begin
                        state      <= ACCESS;
                        cnt        <= dec_wait;
                        o_addr     <= i_addr;
                        o_wdata    <= i_wdata;
                        o_rnw      <= req_rnw;
                        region_l   <= dec_idx;
                        hit_l      <= dec_hit;
                        o_ce       <= dec_onehot;
                        o_rdy      <= 1'b0;
                        o_we       <= !req_rnw && (dec_wait == '0);
                        // Unmapped space always has zero waits, so this is the last access cycle.
                        o_unmapped <= !dec_hit;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state      <= COMPLETE;
                        o_rdy      <= 1'b1;
                        o_ce       <= '0;
                        o_we       <= 1'b0;
                        o_unmapped <= 1'b0;
                        last_valid <= 1'b1;
                        last_addr  <= o_addr;
                        last_rnw   <= o_rnw;
                        if (!o_rnw) begin
                            o_rdata <= o_wdata;
                        end else if (hit_l) begin
                            o_rdata <= rd_sel;
                        end else if (!OPEN_BUS_MODE) begin
                            o_rdata <= DEFAULT_DATA;
                        end
                    end else begin
                        cnt  <= cnt - 1'b1;
                        o_we <= !o_rnw && (cnt == WAIT_W'(1));
                    end
                end
                COMPLETE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gametank_bus_ctrl.sv
// Scoreboard bench for gametank_bus_ctrl with the default map; a second instance
// runs with open-bus emulation disabled on the same stimulus.
module tb_gametank_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        nrd;
    logic        nwr;
    logic [7:0]  wdata;
    logic [31:0] region_rdata;

    logic [7:0]  rdata_a, rdata_b;
    logic        rdy_a, rdy_b;
    logic [3:0]  ce_a, ce_b;
    logic        rnw_a, rnw_b;
    logic [15:0] addr_a, addr_b;
    logic [7:0]  wdata_a, wdata_b;
    logic        we_a, we_b;
    logic        unm_a, unm_b;
    logic        err_a, err_b;

    always #5 clk = ~clk;

    gametank_bus_ctrl dut_a (
        .sys_clk (clk), .reset (rst), .i_addr (addr), .i_nrd (nrd), .i_nwr (nwr),
        .i_wdata (wdata), .o_rdata (rdata_a), .o_rdy (rdy_a), .o_ce (ce_a),
        .o_rnw (rnw_a), .o_addr (addr_a), .o_wdata (wdata_a), .o_we (we_a),
        .i_rdata (region_rdata), .o_unmapped (unm_a), .o_bus_err (err_a)
    );

    gametank_bus_ctrl #(.OPEN_BUS_MODE(1'b0)) dut_b (
        .sys_clk (clk), .reset (rst), .i_addr (addr), .i_nrd (nrd), .i_nwr (nwr),
        .i_wdata (wdata), .o_rdata (rdata_b), .o_rdy (rdy_b), .o_ce (ce_b),
        .o_rnw (rnw_b), .o_addr (addr_b), .o_wdata (wdata_b), .o_we (we_b),
        .i_rdata (region_rdata), .o_unmapped (unm_b), .o_bus_err (err_b)
    );

    typedef struct {
        logic [15:0] addr;
        logic        rnw;
        logic [3:0]  ce;
        int          stall;
        int          we;
        int          unm;
        logic [7:0]  rdata;
        logic [7:0]  rdata_b;
        logic [7:0]  wdata;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int total_we = 0;
    int n_writes = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: gather one access while o_rdy is low, compare in the completion cycle.
    bit          in_acc = 1'b0;
    int          m_stall, m_we, m_unm;
    logic [3:0]  m_ce;
    logic [15:0] m_addr;
    logic        m_rnw;
    logic [7:0]  m_wdata;

    always @(negedge clk) begin
        if (we_a) total_we++;
        if (rst) begin
            in_acc = 1'b0;
        end else if (!rdy_a) begin
            if (!in_acc) begin
                in_acc  = 1'b1;
                m_stall = 0;
                m_we    = 0;
                m_unm   = 0;
                m_ce    = ce_a;
                m_addr  = addr_a;
                m_rnw   = rnw_a;
                m_wdata = wdata_a;
            end
            m_stall++;
            if (we_a) m_we++;
            if (unm_a) m_unm++;
        end else if (in_acc) begin
            in_acc = 1'b0;
            if (sb.size() == 0) begin
                check("sb_unexpected_access", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("addr",     32'(m_addr),  32'(e.addr));
                check("rnw",      32'(m_rnw),   32'(e.rnw));
                check("ce",       32'(m_ce),    32'(e.ce));
                check("stall",    32'(m_stall), 32'(e.stall));
                check("we_pulse", 32'(m_we),    32'(e.we));
                check("unmapped", 32'(m_unm),   32'(e.unm));
                check("rdata",    32'(rdata_a), 32'(e.rdata));
                check("rdata_ob0",32'(rdata_b), 32'(e.rdata_b));
                if (!e.rnw) check("wdata", 32'(m_wdata), 32'(e.wdata));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One strobe pulse, then idle long enough for the access to finish.
    task automatic do_access(input logic [15:0] a, input logic rd, input logic wr,
                             input logic [7:0] d, input logic [3:0] ce, input int w,
                             input logic [7:0] exp_a, input logic [7:0] exp_b);
        exp_t e;
        e.addr = a; e.rnw = !wr; e.ce = ce; e.stall = w + 1;
        e.we = wr ? 1 : 0; e.unm = (ce == 4'b0000) ? 1 : 0;
        e.rdata = exp_a; e.rdata_b = exp_b; e.wdata = d;
        sb.push_back(e);
        if (wr) n_writes++;
        addr = a; nrd = !rd; nwr = !wr; wdata = d;
        tick(1);
        nrd = 1'b1; nwr = 1'b1;
        tick(w + 3);
    endtask

    initial begin
        int we_before;
        exp_t e;
        rst = 1'b1; nrd = 1'b1; nwr = 1'b1; addr = 16'h0000; wdata = 8'h00;
        region_rdata = {8'h33, 8'h22, 8'h11, 8'hA9};
        tick(3);
        check("rst_rdy",      32'(rdy_a),   32'd1);
        check("rst_ce",       32'(ce_a),    32'd0);
        check("rst_we",       32'(we_a),    32'd0);
        check("rst_rnw",      32'(rnw_a),   32'd1);
        check("rst_addr",     32'(addr_a),  32'd0);
        check("rst_wdata",    32'(wdata_a), 32'd0);
        check("rst_rdata",    32'(rdata_a), 32'hFF);
        check("rst_unmapped", 32'(unm_a),   32'd0);
        check("rst_bus_err",  32'(err_a),   32'd0);
        check("rst_rdata_ob0",32'(rdata_b), 32'hFF);
        rst = 1'b0;
        tick(1);

        // addr, rd, wr, wdata, ce, wait, rdata(open bus), rdata(default mode)
        do_access(16'h8123, 1, 0, 8'h00, 4'b0001, 1, 8'hA9, 8'hA9);
        do_access(16'h3000, 1, 0, 8'h00, 4'b0000, 0, 8'hA9, 8'hFF);
        do_access(16'h0042, 0, 1, 8'h5A, 4'b0010, 0, 8'h5A, 8'h5A);
        do_access(16'h3000, 0, 1, 8'h77, 4'b0000, 0, 8'h77, 8'h77);
        do_access(16'h2810, 1, 0, 8'h00, 4'b0000, 0, 8'h77, 8'hFF);
        do_access(16'h4000, 1, 0, 8'h00, 4'b1000, 2, 8'h33, 8'h33);
        do_access(16'h7FFF, 1, 0, 8'h00, 4'b1000, 2, 8'h33, 8'h33);
        do_access(16'h2800, 1, 0, 8'h00, 4'b0100, 1, 8'h22, 8'h22);
        do_access(16'h280F, 1, 0, 8'h00, 4'b0100, 1, 8'h22, 8'h22);
        do_access(16'h2000, 1, 0, 8'h00, 4'b0000, 0, 8'h22, 8'hFF);
        do_access(16'hFFFF, 1, 0, 8'h00, 4'b0001, 1, 8'hA9, 8'hA9);
        do_access(16'h1FFF, 1, 0, 8'h00, 4'b0010, 0, 8'h11, 8'h11);
        do_access(16'h7000, 0, 1, 8'hC5, 4'b1000, 2, 8'hC5, 8'hC5);

        // Held read strobe: one access, then a second only when the address moves.
        e.addr = 16'h8000; e.rnw = 1'b1; e.ce = 4'b0001; e.stall = 2; e.we = 0; e.unm = 0;
        e.rdata = 8'hA9; e.rdata_b = 8'hA9; e.wdata = 8'h00;
        sb.push_back(e);
        addr = 16'h8000; nrd = 1'b0;
        tick(10);
        region_rdata[7:0] = 8'hC3;
        e.addr = 16'h8001; e.rdata = 8'hC3; e.rdata_b = 8'hC3;
        sb.push_back(e);
        addr = 16'h8001;
        tick(6);
        nrd = 1'b1;
        tick(3);

        // Both strobes low: performed as a write, error flag sticks.
        check("bus_err_before", 32'(err_a), 32'd0);
        do_access(16'h2801, 1, 1, 8'h3C, 4'b0100, 1, 8'h3C, 8'h3C);
        check("bus_err_set",     32'(err_a), 32'd1);
        check("bus_err_set_ob0", 32'(err_b), 32'd1);
        do_access(16'h8123, 1, 0, 8'h00, 4'b0001, 1, 8'hC3, 8'hC3);
        check("bus_err_sticky",  32'(err_a), 32'd1);

        // Reset in the middle of a wait=2 write.
        we_before = total_we;
        addr = 16'h4000; nwr = 1'b0; wdata = 8'hE7;
        tick(1);
        nwr = 1'b1;
        check("abort_in_access_rdy", 32'(rdy_a), 32'd0);
        check("abort_in_access_ce",  32'(ce_a),  32'b1000);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_rdy",      32'(rdy_a),   32'd1);
        check("abort_ce",       32'(ce_a),    32'd0);
        check("abort_we",       32'(we_a),    32'd0);
        check("abort_rdata",    32'(rdata_a), 32'hFF);
        check("abort_rdata_ob0",32'(rdata_b), 32'hFF);
        check("abort_bus_err",  32'(err_a),   32'd0);
        tick(5);
        check("abort_no_we", 32'(total_we), 32'(we_before));

        do_access(16'h8123, 1, 0, 8'h00, 4'b0001, 1, 8'hC3, 8'hC3);

        check("sb_drained",   32'(sb.size()), 32'd0);
        check("we_total",     32'(total_we),  32'(n_writes));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
